// File: rtl/rx_read_arbiter.sv
// Purpose: shares the receive FIFO read port between CPU (port 0) and DMA (port 1) requesters.
// Latency: grant 1 cycle after request with data present; byte+ack 1 cycle after the pop decision.
// Backpressure: pops only while the granted requester holds its request and the FIFO has data.
module rx_read_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int BCNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_dor,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    input  logic       req0,
    input  logic       req1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [1:0] gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(BURST_MAX);

    state_t            state;
    state_t            state_nxt;
    logic [BCNT_W-1:0] bcnt;
    // Priority pointer: 0 names the CPU port, 1 names the DMA port.
    logic              prio;
    logic              cur_req;
    logic              oth_req;
    logic              release_g;
    logic              pop;

    // Next-state, release and pop decision for the current grant.
    always_comb begin
        state_nxt = state;
        cur_req   = 1'b0;
        oth_req   = 1'b0;
        release_g = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_dor && (req0 || req1)) begin
                    if (req0 && req1) begin
                        state_nxt = prio ? GNT1 : GNT0;
                    end else if (req0) begin
                        state_nxt = GNT0;
                    end else begin
                        state_nxt = GNT1;
                    end
                end
            end
            GNT0, GNT1: begin
                cur_req = (state == GNT0) ? req0 : req1;
                oth_req = (state == GNT0) ? req1 : req0;
                // The CPU grant ends in its ack cycle (fifo_rd high) so it gets one byte.
                release_g = !cur_req || !fifo_dor ||
                            ((bcnt == BMAX) && oth_req) ||
                            ((state == GNT0) && fifo_rd);
                // A pop needs a free decision cycle: never back-to-back with the previous pop.
                pop = cur_req && fifo_dor && !fifo_rd && !release_g;
                if (release_g) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop strobe, ack pulses, captured byte, burst count and priority pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_rd <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= 8'h00;
            bcnt    <= '0;
            prio    <= 1'b0;
        end else begin
            fifo_rd <= pop;
            ack0    <= pop && (state == GNT0);
            ack1    <= pop && (state == GNT1);
            if (pop) begin
                rdata <= fifo_dout;
                if (bcnt != BMAX) begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            if (release_g) begin
                bcnt <= '0;
                // The port just released loses priority to the other one.
                prio <= (state == GNT0);
            end
        end
    end

    assign gnt = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_rx_read_arbiter.sv
// Purpose: scoreboard bench for rx_read_arbiter with a queue-based FIFO and requester agents.
// Latency: expectations are queued at FIFO write time and consumed on each ack pulse.
// Backpressure: CPU agent drops req0 on ack0; DMA agent holds req1 at will.
module tb_rx_read_arbiter;
    localparam int BURST_MAX = 4;
    localparam int BCNT_W    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0;
    logic       req1;
    logic       fifo_dor  = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic [1:0] gnt;

    typedef struct packed {
        logic [7:0] data;
        logic       port;
        logic       chk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    exp_t       e;
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         cyc       = 0;
    int         fair_cnt  = 0;
    logic       prev_req0 = 1'b0;
    logic       prev_req1 = 1'b0;
    bit         cpu_auto  = 1'b1;

    rx_read_arbiter #(.BURST_MAX(BURST_MAX), .BCNT_W(BCNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_dor  (fifo_dor),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .req0      (req0),
        .req1      (req1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .gnt       (gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    // Advance to just after the next rising edge; the CPU agent withdraws on its ack.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_auto && ack0) req0 = 1'b0;
    endtask

    // Write one byte into the FIFO model and queue what the host side should see for it.
    task automatic put(input logic [7:0] d, input logic port, input logic chk);
        exp_t x;
        x.data = d;
        x.port = port;
        x.chk  = chk;
        fq.push_back(d);
        sb.push_back(x);
    endtask

    // Monitor and FIFO model: checks every presented byte, then pops on the falling edge.
    always @(negedge clk) begin
        check("inv_rd_eq_ack", {31'd0, fifo_rd}, {31'd0, ack0 | ack1});
        check("inv_ack_excl", {31'd0, ack0 & ack1}, 32'd0);
        check("inv_gnt_onehot", {31'd0, gnt == 2'b11}, 32'd0);
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                flag("unexpected_ack", "ack with no byte outstanding");
            end else begin
                e = sb.pop_front();
                check("ack_data", {24'd0, rdata}, {24'd0, e.data});
                if (e.chk) check("ack_port", {31'd0, ack1}, {31'd0, e.port});
            end
            if (ack0) check("ack0_req_at_decision", {31'd0, prev_req0}, 32'd1);
            if (ack1) check("ack1_req_at_decision", {31'd0, prev_req1}, 32'd1);
        end
        if (ack1 && prev_req0) begin
            fair_cnt++;
            check("fairness_bound", {31'd0, fair_cnt <= BURST_MAX}, 32'd1);
        end else if (ack0 || !prev_req0) begin
            fair_cnt = 0;
        end
        if (fifo_rd) begin
            if (fq.size() == 0) flag("pop_empty", "fifo_rd while FIFO empty");
            else void'(fq.pop_front());
        end
        fifo_dor  = (fq.size() != 0);
        fifo_dout = (fq.size() != 0) ? fq[0] : 8'h00;
        prev_req0 = req0;
        prev_req1 = req1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_cyc[$];
        int n;
        int cnt;

        // Reset with both requesting and data present; CPU must win first.
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        put(8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
            check("rst_ack0", {31'd0, ack0}, 32'd0);
            check("rst_ack1", {31'd0, ack1}, 32'd0);
            check("rst_gnt", {30'd0, gnt}, 32'd0);
            check("rst_rdata", {24'd0, rdata}, 32'd0);
        end
        reset = 1'b0;
        tick();
        check("t1_first_grant", {30'd0, gnt}, 32'd1);
        n = 0;
        while (!ack0 && n < 10) begin
            tick();
            n++;
        end
        check("t1_ack0_seen", {31'd0, ack0}, 32'd1);
        req1 = 1'b0;
        repeat (3) tick();

        // CPU single read, request held through the ack: still exactly one byte.
        put(8'hA5, 1'b0, 1'b1);
        put(8'h6B, 1'b0, 1'b1);
        tick();
        cpu_auto = 1'b0;
        req0 = 1'b1;
        tick();
        check("t2_gnt", {30'd0, gnt}, 32'd1);
        check("t2_no_early_ack", {31'd0, ack0}, 32'd0);
        tick();
        check("t2_ack0", {31'd0, ack0}, 32'd1);
        check("t2_rdata", {24'd0, rdata}, 32'hA5);
        check("t2_fifo_rd", {31'd0, fifo_rd}, 32'd1);
        tick();
        check("t2_released", {30'd0, gnt}, 32'd0);
        check("t2_single_ack", {31'd0, ack0}, 32'd0);
        req0 = 1'b0;
        cpu_auto = 1'b1;
        tick();
        tick();
        check("t2_idle_no_req", {30'd0, gnt}, 32'd0);
        req0 = 1'b1;
        n = 0;
        while (!ack0 && n < 10) begin
            tick();
            n++;
        end
        check("t2_second_read", {31'd0, ack0}, 32'd1);
        repeat (3) tick();

        // DMA burst of three bytes, acks two cycles apart, release on empty.
        put(8'h11, 1'b1, 1'b1);
        put(8'h22, 1'b1, 1'b1);
        put(8'h33, 1'b1, 1'b1);
        tick();
        req1 = 1'b1;
        n = 0;
        while (ack_cyc.size() < 3 && n < 30) begin
            tick();
            n++;
            if (ack1) ack_cyc.push_back(cyc);
        end
        check("t3_ack_count", ack_cyc.size(), 32'd3);
        if (ack_cyc.size() == 3) begin
            check("t3_gap1", ack_cyc[1] - ack_cyc[0], 32'd2);
            check("t3_gap2", ack_cyc[2] - ack_cyc[1], 32'd2);
        end
        tick();
        check("t3_release_empty", {30'd0, gnt}, 32'd0);
        repeat (3) tick();
        req1 = 1'b0;
        tick();

        // Fairness: DMA gets BURST_MAX bytes, CPU the 5th, DMA the 6th.
        for (int i = 0; i < 6; i++) begin
            put(8'h41 + 8'(i), (i == 4) ? 1'b0 : 1'b1, 1'b1);
        end
        tick();
        req1 = 1'b1;
        tick();
        req0 = 1'b1;
        n = 0;
        cnt = 0;
        while (cnt < 6 && n < 60) begin
            tick();
            n++;
            if (ack0 || ack1) cnt++;
        end
        check("t4_ack_count", cnt, 32'd6);
        req1 = 1'b0;
        repeat (3) tick();

        // Both requests rise on an empty FIFO; the byte goes to the pointer port (CPU: DMA was last).
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_idle_empty", {30'd0, gnt}, 32'd0);
        end
        put(8'h5A, 1'b0, 1'b1);
        n = 0;
        while (!(ack0 || ack1) && n < 10) begin
            tick();
            n++;
        end
        check("t5_ack0", {31'd0, ack0}, 32'd1);
        req1 = 1'b0;
        repeat (3) tick();

        // Randomised traffic: data order, request legality and fairness checked by the monitor.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 12) put(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            if (!req0 && $urandom_range(0, 11) == 0) req0 = 1'b1;
            tick();
        end
        req1 = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_sb_empty", sb.size(), 32'd0);
        check("drain_fifo_empty", fq.size(), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) tick();

        // Reset in an ack1 cycle: outputs clear and no further pop.
        for (int i = 0; i < 4; i++) put(8'hC0 + 8'(i), 1'b1, 1'b1);
        tick();
        req1 = 1'b1;
        n = 0;
        while (!ack1 && n < 10) begin
            tick();
            n++;
        end
        check("t6_ack1_seen", {31'd0, ack1}, 32'd1);
        reset = 1'b1;
        req1  = 1'b0;
        tick();
        check("t6_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("t6_ack0", {31'd0, ack0}, 32'd0);
        check("t6_ack1", {31'd0, ack1}, 32'd0);
        check("t6_gnt", {30'd0, gnt}, 32'd0);
        check("t6_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        check("t6_fifo_level", fq.size(), 32'd3);
        check("t6_idle", {30'd0, gnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
